// File: rtl/cache_perf_monitor.sv
// Cache access monitor: classifies each request/response access as hit or miss and counts stall cycles.
// Counts visible one cycle after the classifying edge; observes only, never applies backpressure.
module cache_perf_monitor #(
    parameter int WIDTH       = 16,
    parameter int HIT_LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             mem_resp,
    input  logic             clear,
    output logic [WIDTH-1:0] hit_count,
    output logic [WIDTH-1:0] miss_count,
    output logic [WIDTH-1:0] miss_cycle_count,
    output logic             busy
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam logic [3:0] HIT_LAT = 4'(HIT_LATENCY);
    localparam logic [3:0] LAT_MAX = 4'hF;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] lat;
    logic [3:0] lat_nxt;
    logic       req;
    logic       hit_ev;
    logic       miss_ev;
    logic       wait_ev;

    assign req = mem_read | mem_write;

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        return (&v) ? v : v + WIDTH'(1);
    endfunction

    // Stall cycles include the completing cycle, so an access finishing at
    // latency L adds exactly L - HIT_LATENCY to miss_cycle_count.
    always_comb begin
        state_nxt = state;
        lat_nxt   = lat;
        hit_ev    = 1'b0;
        miss_ev   = 1'b0;
        wait_ev   = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    wait_ev = (4'd1 > HIT_LAT);
                    if (mem_resp) begin
                        hit_ev  = (4'd1 <= HIT_LAT);
                        miss_ev = (4'd1 > HIT_LAT);
                    end else begin
                        state_nxt = ACTIVE;
                        lat_nxt   = 4'd2;
                    end
                end
            end
            ACTIVE: begin
                if (mem_resp) begin
                    wait_ev   = (lat > HIT_LAT);
                    hit_ev    = (lat <= HIT_LAT);
                    miss_ev   = (lat > HIT_LAT);
                    state_nxt = IDLE;
                    lat_nxt   = 4'd0;
                end else if (req) begin
                    wait_ev = (lat > HIT_LAT);
                    lat_nxt = (lat == LAT_MAX) ? LAT_MAX : lat + 4'd1;
                end else begin
                    state_nxt = IDLE;
                    lat_nxt   = 4'd0;
                end
            end
            default: begin
                state_nxt = IDLE;
                lat_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            lat   <= 4'd0;
        end else begin
            state <= state_nxt;
            lat   <= lat_nxt;
        end
    end

    // Clear only zeroes the counters; an in-flight access keeps its latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count        <= '0;
            miss_count       <= '0;
            miss_cycle_count <= '0;
        end else if (clear) begin
            hit_count        <= '0;
            miss_count       <= '0;
            miss_cycle_count <= '0;
        end else begin
            if (hit_ev)  hit_count        <= sat_inc(hit_count);
            if (miss_ev) miss_count       <= sat_inc(miss_count);
            if (wait_ev) miss_cycle_count <= sat_inc(miss_cycle_count);
        end
    end

    assign busy = (state == ACTIVE);

endmodule

// File: tb/tb_cache_perf_monitor.sv
// Directed bench for cache_perf_monitor with hand-computed expected counts (HIT_LATENCY=1, WIDTH=16).
module tb_cache_perf_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic        mem_resp = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] hit_count;
    logic [15:0] miss_count;
    logic [15:0] miss_cycle_count;
    logic        busy;

    int total = 0;
    int bad   = 0;

    cache_perf_monitor #(.WIDTH(16), .HIT_LATENCY(1)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .mem_resp         (mem_resp),
        .clear            (clear),
        .hit_count        (hit_count),
        .miss_count       (miss_count),
        .miss_cycle_count (miss_cycle_count),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        mem_read = 0; mem_write = 0; mem_resp = 0; clear = 0;
        rst_n = 0;
        #2;
        rst_n = 1;
    endtask

    task automatic test_reset();
        #1;
        total++; if (hit_count !== 16'd0) begin bad++; $display("FAIL reset_hit got=%0h exp=0", hit_count); end
        total++; if (miss_count !== 16'd0) begin bad++; $display("FAIL reset_miss got=%0h exp=0", miss_count); end
        total++; if (miss_cycle_count !== 16'd0) begin bad++; $display("FAIL reset_mcc got=%0h exp=0", miss_cycle_count); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tick();
        do_reset();
    endtask

    task automatic test_single_hit();
        do_reset();
        mem_read = 1; mem_resp = 1;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL hit_busy got=%b exp=0", busy); end
        mem_read = 0; mem_resp = 0;
        total++; if (hit_count !== 16'd1) begin bad++; $display("FAIL hit_hit got=%0h exp=1", hit_count); end
        total++; if (miss_count !== 16'd0) begin bad++; $display("FAIL hit_miss got=%0h exp=0", miss_count); end
        total++; if (miss_cycle_count !== 16'd0) begin bad++; $display("FAIL hit_mcc got=%0h exp=0", miss_cycle_count); end
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL hit_busy_after got=%b exp=0", busy); end
    endtask

    task automatic test_miss();
        do_reset();
        mem_write = 1;
        for (int k = 1; k <= 5; k++) begin
            mem_resp = (k == 5);
            total++; if (busy !== (k >= 2)) begin bad++; $display("FAIL miss_busy_c%0d got=%b exp=%b", k, busy, (k >= 2)); end
            tick();
        end
        mem_write = 0; mem_resp = 0;
        total++; if (miss_count !== 16'd1) begin bad++; $display("FAIL miss_miss got=%0h exp=1", miss_count); end
        total++; if (miss_cycle_count !== 16'd4) begin bad++; $display("FAIL miss_mcc got=%0h exp=4", miss_cycle_count); end
        total++; if (hit_count !== 16'd0) begin bad++; $display("FAIL miss_hit got=%0h exp=0", hit_count); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL miss_busy_end got=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        mem_read = 1; mem_resp = 1;
        tick();
        total++; if (hit_count !== 16'd1) begin bad++; $display("FAIL b2b_first_hit got=%0h exp=1", hit_count); end
        mem_resp = 0;
        tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%b exp=1", busy); end
        tick();
        mem_resp = 1;
        tick();
        mem_read = 0; mem_resp = 0;
        total++; if (hit_count !== 16'd1) begin bad++; $display("FAIL b2b_hit got=%0h exp=1", hit_count); end
        total++; if (miss_count !== 16'd1) begin bad++; $display("FAIL b2b_miss got=%0h exp=1", miss_count); end
        total++; if (miss_cycle_count !== 16'd2) begin bad++; $display("FAIL b2b_mcc got=%0h exp=2", miss_cycle_count); end
    endtask

    task automatic test_abandon_and_ignore();
        do_reset();
        mem_read = 1;
        tick();
        mem_read = 0;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abandon_busy got=%b exp=0", busy); end
        total++; if ((hit_count | miss_count | miss_cycle_count) !== 16'd0) begin bad++; $display("FAIL abandon_counts got=%0h/%0h/%0h exp=0/0/0", hit_count, miss_count, miss_cycle_count); end
        mem_resp = 1;
        tick();
        mem_resp = 0;
        total++; if ((hit_count | miss_count) !== 16'd0 || busy !== 1'b0) begin bad++; $display("FAIL ignore_resp got=%0h/%0h busy=%b exp=0/0 busy=0", hit_count, miss_count, busy); end
        mem_read = 1; mem_write = 1; mem_resp = 1;
        tick();
        mem_read = 0; mem_write = 0; mem_resp = 0;
        total++; if (hit_count !== 16'd1) begin bad++; $display("FAIL both_req_hit got=%0h exp=1", hit_count); end
    endtask

    task automatic test_clear_mid_miss();
        do_reset();
        mem_read = 1; mem_resp = 1;
        tick();
        mem_resp = 0;
        total++; if (hit_count !== 16'd1) begin bad++; $display("FAIL clr_pre_hit got=%0h exp=1", hit_count); end
        mem_read = 0;
        tick();
        mem_read = 1;
        tick();
        clear = 1;
        tick();
        clear = 0;
        total++; if ((hit_count | miss_count | miss_cycle_count) !== 16'd0) begin bad++; $display("FAIL clr_zero got=%0h/%0h/%0h exp=0/0/0", hit_count, miss_count, miss_cycle_count); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL clr_busy got=%b exp=1", busy); end
        tick();
        mem_resp = 1;
        tick();
        mem_read = 0; mem_resp = 0;
        total++; if (miss_count !== 16'd1) begin bad++; $display("FAIL clr_miss got=%0h exp=1", miss_count); end
        total++; if (miss_cycle_count !== 16'd2) begin bad++; $display("FAIL clr_mcc got=%0h exp=2", miss_cycle_count); end
        total++; if (hit_count !== 16'd0) begin bad++; $display("FAIL clr_hit got=%0h exp=0", hit_count); end
    endtask

    task automatic test_reset_mid_access();
        do_reset();
        mem_write = 1;
        tick();
        tick();
        total++; if (miss_cycle_count !== 16'd1) begin bad++; $display("FAIL rst_mid_pre_mcc got=%0h exp=1", miss_cycle_count); end
        rst_n = 0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
        total++; if ((hit_count | miss_count | miss_cycle_count) !== 16'd0) begin bad++; $display("FAIL rst_mid_counts got=%0h/%0h/%0h exp=0/0/0", hit_count, miss_count, miss_cycle_count); end
        mem_write = 0;
        #1;
        rst_n = 1;
        mem_read = 1; mem_resp = 1;
        tick();
        mem_read = 0; mem_resp = 0;
        total++; if (hit_count !== 16'd1) begin bad++; $display("FAIL rst_mid_hit got=%0h exp=1", hit_count); end
        total++; if (miss_count !== 16'd0) begin bad++; $display("FAIL rst_mid_miss got=%0h exp=0", miss_count); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy_after got=%b exp=0", busy); end
    endtask

    task automatic test_saturation();
        do_reset();
        mem_read = 1; mem_resp = 1;
        repeat (65534) @(posedge clk);
        #1;
        total++; if (hit_count !== 16'hFFFE) begin bad++; $display("FAIL sat_preload got=%0h exp=fffe", hit_count); end
        for (int k = 1; k <= 3; k++) begin
            tick();
            total++; if (hit_count !== 16'hFFFF) begin bad++; $display("FAIL sat_hold_%0d got=%0h exp=ffff", k, hit_count); end
        end
        mem_read = 0; mem_resp = 0;
        total++; if (miss_count !== 16'd0) begin bad++; $display("FAIL sat_miss got=%0h exp=0", miss_count); end
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_miss();
        test_back_to_back();
        test_abandon_and_ignore();
        test_clear_mid_miss();
        test_reset_mid_access();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
